calc_sequencer: RTL
===================

// Module: calc_sequencer
// PURPOSE
//  Keypad-driven sequencer for the calculator ALU. Builds signed operands (+/-999) from
//  decimal key events, and issues a one-cycle compute strobe with the opcode. It captures
//  result/remainder and drives display values. It sits between keypad decoder and ALU/display mux.
// PARAMETERS
//  DIGITS       3    max decimal digits per operand
//  MAXMAG       999  max operand magnitude; also the chaining limit
//  ALU_LATENCY  1    cycles after the strobe edge before alu_result is valid (>=1)
// PORTS
//  clock          in   1   system clock, all logic on posedge
//  resetn         in   1   synchronous reset, active low
//  key_valid      in   1   one-cycle pulse, key_code valid
//  key_code       in   5   0-9 digit, 16 ADD, 17 SUB, 18 MUL, 19 DIV, 20 EQ, 21 CLR, 22 NEG; others ignored
//  alu_a          out  11  signed operand A (ALU regA)
//  alu_b          out  11  signed operand B (ALU regB)
//  alu_opcode     out  2   00 add, 01 sub, 10 mul, 11 div
//  alu_strobe     out  1   registered, high exactly one cycle per compute
//  alu_result     in   21  signed ALU result
//  alu_remainder  in   21  ALU remainder; alu_remain in 1 = remainder nonzero
//  disp_value     out  21  signed value to display
//  disp_rem       out  21  remainder to display; disp_rem_en out 1 = show remainder
//  busy           out  1   high in COMPUTE/WAIT
//  done           out  1   one-cycle pulse on SHOW entry
//  error          out  1   high in ERROR; err_code out 2: 01 div0, 10 overflow
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state ENTER_A. All outputs and entries are 0: alu_strobe=0, done=0, error=0.
//  Entry: mag=mag*10+d if digit count<DIGITS, else the digit is ignored. Leading zeros count as digits.
//   NEG toggles the sign; -0 is sent as 0. The value is sign?-mag:mag. disp_value shows the active entry.
//  States:
//   ENTER_A: digit/NEG edit A. ADD..DIV latch op, go to ENTER_B (A=0 if no digits). EQ is ignored.
//   ENTER_B: digit/NEG edit B. An op key with 0 B digits replaces the op; with B digits it is ignored.
//    EQ with 0 B digits is ignored. EQ with DIV and B==0 goes to ERROR(div0) with no strobe.
//    Otherwise EQ goes to COMPUTE.
//   COMPUTE: alu_strobe=1 for one cycle; alu_a/b/opcode stable from this cycle until SHOW. Go to WAIT.
//   WAIT: hold ALU_LATENCY cycles. Then capture disp_value=alu_result.
//    For DIV, disp_rem=alu_remainder and disp_rem_en=alu_remain; otherwise both are 0. Go to SHOW, done=1.
//   SHOW: an op key with |result|<=MAXMAG loads A=result, latches op, and goes to ENTER_B.
//    An op key with |result|>MAXMAG goes to ERROR(overflow).
//    A digit clears the entries and starts a new A with that digit. EQ/NEG are ignored.
//   ERROR: only CLR exits (to ENTER_A, all cleared); disp_value=0.
//  CLR in any state: go to ENTER_A next cycle and clear entries, op, display and error.
//   CLR in COMPUTE/WAIT discards the ALU result; no done pulse.
//  Non-CLR keys during COMPUTE/WAIT are dropped (no queueing).
//  Latency (ALU_LATENCY=1): EQ sampled at edge 0 -> strobe high cycle 1 -> capture edge 2 -> done cycle 3.
//  Key codes >22 are ignored in all states.
//  Multiply by 10 is (m<<3)+(m<<1); there is no multiplier instance.
// STRUCTURE
//  calc_defs.vh: key codes, opcode defines (shared with the ALU), state encodings, err codes.
//  Sub-module calc_entry: digit/sign accumulator (mag, sign, count; load/clear/digit/neg ports).
//   It is instantiated twice (A, B).
//  Top module: FSM, WAIT counter, capture registers.
// TESTING
//  1 2 ADD 3 4 EQ -> one strobe, opcode 00, a=12, b=34; done 3 cycles after EQ; disp_value=46.
//  7 NEG MUL 8 EQ -> a=-7, b=8; disp_value=-56; disp_rem_en=0.
//  1 7 NEG DIV 5 EQ -> a=-17; disp_value=-4, disp_rem=3, disp_rem_en=1.
//  5 DIV 0 EQ -> no strobe; error=1, err_code=01; only CLR recovers.
//  9 9 9 MUL 9 9 9 EQ -> 998001; then ADD -> ERROR(10).
//  4 SUB 9 EQ -> -5; then ADD 2 EQ chains to -3.
//  1 2 3 4 -> disp_value=123 (4th digit ignored).
//  CLR during WAIT -> no done; disp_value=0.
//  resetn low mid-entry -> all outputs 0 next cycle.

Source files
------------

// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the calculator sequencer: key codes, ALU opcodes,
// FSM states and error codes.
package calc_sequencer_pkg;

  localparam int unsigned MAG_W = 10;  // holds magnitudes up to 999
  localparam int unsigned VAL_W = 11;  // signed operand width
  localparam int unsigned RES_W = 21;  // signed ALU result width

  localparam logic [4:0] KEY_ADD = 5'd16;
  localparam logic [4:0] KEY_SUB = 5'd17;
  localparam logic [4:0] KEY_MUL = 5'd18;
  localparam logic [4:0] KEY_DIV = 5'd19;
  localparam logic [4:0] KEY_EQ  = 5'd20;
  localparam logic [4:0] KEY_CLR = 5'd21;
  localparam logic [4:0] KEY_NEG = 5'd22;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_COMPUTE,
    S_WAIT,
    S_SHOW,
    S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  function automatic logic is_op_key(input logic [4:0] code);
    return (code >= KEY_ADD) && (code <= KEY_DIV);
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad, ALU and display signals of the calculator sequencer.
interface calc_sequencer_if;
  logic               key_valid;
  logic        [4:0]  key_code;
  logic signed [10:0] alu_a;
  logic signed [10:0] alu_b;
  logic        [1:0]  alu_opcode;
  logic               alu_strobe;
  logic signed [20:0] alu_result;
  logic signed [20:0] alu_remainder;
  logic               alu_remain;
  logic signed [20:0] disp_value;
  logic signed [20:0] disp_rem;
  logic               disp_rem_en;
  logic               busy;
  logic               done;
  logic               error;
  logic        [1:0]  err_code;

  modport slave (
    input  key_valid, key_code, alu_result, alu_remainder, alu_remain,
    output alu_a, alu_b, alu_opcode, alu_strobe, disp_value, disp_rem,
           disp_rem_en, busy, done, error, err_code
  );

  modport master (
    output key_valid, key_code, alu_result, alu_remainder, alu_remain,
    input  alu_a, alu_b, alu_opcode, alu_strobe, disp_value, disp_rem,
           disp_rem_en, busy, done, error, err_code
  );
endinterface

// File: rtl/calc_sequencer_entry.sv
// Decimal digit/sign accumulator for one signed operand.
import calc_sequencer_pkg::*;

module calc_entry #(
  parameter int unsigned DIGITS = 3
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic                    load,
  input  logic [MAG_W-1:0]        load_mag,
  input  logic                    load_neg,
  input  logic                    digit_en,
  input  logic [3:0]              digit,
  input  logic                    neg,
  output logic signed [VAL_W-1:0] value,
  output logic                    any
);
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] DIG_MAX = CW'(DIGITS);

  logic [MAG_W-1:0] mag, mag_n, base_mag;
  logic [CW-1:0]    cnt, cnt_n, base_cnt;
  logic             sign, sign_n, base_sign;

  // Clear composes with a digit so a fresh entry can start in the same cycle.
  always_comb begin
    base_mag  = clear ? '0 : mag;
    base_cnt  = clear ? '0 : cnt;
    base_sign = clear ? 1'b0 : sign;
    mag_n     = base_mag;
    cnt_n     = base_cnt;
    sign_n    = base_sign;
    if (load) begin
      mag_n  = load_mag;
      cnt_n  = DIG_MAX;
      sign_n = load_neg;
    end else begin
      if (digit_en && (base_cnt < DIG_MAX)) begin
        mag_n = (base_mag << 3) + (base_mag << 1) + MAG_W'(digit);
        cnt_n = base_cnt + CW'(1);
      end
      if (neg) sign_n = ~base_sign;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      mag  <= '0;
      cnt  <= '0;
      sign <= 1'b0;
    end else begin
      mag  <= mag_n;
      cnt  <= cnt_n;
      sign <= sign_n;
    end
  end

  always_comb begin
    value = sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    any   = (cnt != '0);
  end
endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer: builds operands, strobes the ALU, captures the
// result and drives the display.
import calc_sequencer_pkg::*;

module calc_sequencer #(
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned MAXMAG      = 999,
  parameter int unsigned ALU_LATENCY = 1
) (
  input logic            clock,
  input logic            resetn,
  calc_sequencer_if.slave bus
);
  localparam int unsigned LW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [LW-1:0]    WAIT_LAST = LW'(ALU_LATENCY - 1);
  localparam logic [RES_W-1:0] MAG_LIMIT = RES_W'(MAXMAG);

  state_t state, state_n;
  op_t    op_q;
  logic [1:0]              err_q;
  logic signed [RES_W-1:0] res_q, rem_q;
  logic [RES_W-1:0]        res_abs;
  logic                    rem_en_q, strobe_q, done_q, res_big;
  logic [LW-1:0]           wait_cnt;
  logic                    wait_last;

  logic k_digit, k_op, k_eq, k_clr, k_neg;
  logic a_clear, a_load, a_digit, a_neg, b_clear, b_digit, b_neg;
  logic op_load, capture, a_any, b_any;
  logic signed [VAL_W-1:0] a_val, b_val;

  always_comb begin
    k_digit = bus.key_valid && (bus.key_code <= 5'd9);
    k_op    = bus.key_valid && is_op_key(bus.key_code);
    k_eq    = bus.key_valid && (bus.key_code == KEY_EQ);
    k_clr   = bus.key_valid && (bus.key_code == KEY_CLR);
    k_neg   = bus.key_valid && (bus.key_code == KEY_NEG);
    res_abs   = res_q[RES_W-1] ? RES_W'(-res_q) : RES_W'(res_q);
    res_big   = res_abs > MAG_LIMIT;
    wait_last = (wait_cnt == WAIT_LAST);
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_ENTER_A;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (k_clr) state_n = S_ENTER_A;
    else begin
      case (state)
        S_ENTER_A: if (k_op) state_n = S_ENTER_B;
        S_ENTER_B: if (k_eq && b_any)
                     state_n = (op_q == OP_DIV && b_val == '0) ? S_ERROR : S_COMPUTE;
        S_COMPUTE: state_n = S_WAIT;
        S_WAIT:    if (wait_last) state_n = S_SHOW;
        S_SHOW:    if (k_op) state_n = res_big ? S_ERROR : S_ENTER_B;
                   else if (k_digit) state_n = S_ENTER_A;
        S_ERROR:   state_n = S_ERROR;
        default:   state_n = S_ENTER_A;
      endcase
    end
  end

  always_comb begin
    a_clear = 1'b0; a_load = 1'b0; a_digit = 1'b0; a_neg = 1'b0;
    b_clear = 1'b0; b_digit = 1'b0; b_neg = 1'b0;
    op_load = 1'b0; capture = 1'b0;
    if (k_clr) begin
      a_clear = 1'b1;
      b_clear = 1'b1;
    end else begin
      case (state)
        S_ENTER_A: begin
          a_digit = k_digit;
          a_neg   = k_neg;
          op_load = k_op;
          a_clear = k_op && !a_any;
        end
        S_ENTER_B: begin
          b_digit = k_digit;
          b_neg   = k_neg;
          op_load = k_op && !b_any;
        end
        S_WAIT: capture = wait_last;
        S_SHOW: begin
          a_load  = k_op && !res_big;
          op_load = k_op && !res_big;
          a_clear = k_digit;
          a_digit = k_digit;
          b_clear = k_digit || (k_op && !res_big);
        end
        default: ;
      endcase
    end
  end

  calc_entry #(.DIGITS(DIGITS)) u_entry_a (
    .clock(clock), .resetn(resetn), .clear(a_clear), .load(a_load),
    .load_mag(res_abs[MAG_W-1:0]), .load_neg(res_q[RES_W-1]),
    .digit_en(a_digit), .digit(bus.key_code[3:0]), .neg(a_neg),
    .value(a_val), .any(a_any)
  );

  calc_entry #(.DIGITS(DIGITS)) u_entry_b (
    .clock(clock), .resetn(resetn), .clear(b_clear), .load(1'b0),
    .load_mag('0), .load_neg(1'b0),
    .digit_en(b_digit), .digit(bus.key_code[3:0]), .neg(b_neg),
    .value(b_val), .any(b_any)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      op_q     <= OP_ADD;
      err_q    <= ERR_NONE;
      res_q    <= '0;
      rem_q    <= '0;
      rem_en_q <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      wait_cnt <= '0;
    end else begin
      strobe_q <= (state_n == S_COMPUTE);
      done_q   <= capture;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + LW'(1) : '0;
      if (k_clr) begin
        op_q     <= OP_ADD;
        err_q    <= ERR_NONE;
        res_q    <= '0;
        rem_q    <= '0;
        rem_en_q <= 1'b0;
      end else begin
        if (op_load) op_q <= op_t'(bus.key_code[1:0]);
        if (capture) begin
          res_q    <= bus.alu_result;
          rem_q    <= (op_q == OP_DIV) ? bus.alu_remainder : '0;
          rem_en_q <= (op_q == OP_DIV) && bus.alu_remain;
        end else if (state == S_SHOW && state_n != S_SHOW) begin
          rem_q    <= '0;
          rem_en_q <= 1'b0;
        end
        if (state_n == S_ERROR && state != S_ERROR)
          err_q <= (state == S_SHOW) ? ERR_OVF : ERR_DIV0;
      end
    end
  end

  always_comb begin
    bus.alu_a       = a_val;
    bus.alu_b       = b_val;
    bus.alu_opcode  = op_q;
    bus.alu_strobe  = strobe_q;
    bus.done        = done_q;
    bus.busy        = (state == S_COMPUTE) || (state == S_WAIT);
    bus.error       = (state == S_ERROR);
    bus.err_code    = err_q;
    bus.disp_rem    = rem_q;
    bus.disp_rem_en = rem_en_q;
    case (state)
      S_ENTER_A: bus.disp_value = {{(RES_W-VAL_W){a_val[VAL_W-1]}}, a_val};
      S_SHOW:    bus.disp_value = res_q;
      S_ERROR:   bus.disp_value = '0;
      default:   bus.disp_value = {{(RES_W-VAL_W){b_val[VAL_W-1]}}, b_val};
    endcase
  end
endmodule
